// File: rtl/fpu_job_pkg.sv
// fpu_job_pkg: shared definitions for the formula-pipeline job initiator.
//   FLEN, ID_W     : default operand width (IEEE 754 double) and job tag width
//   job_t          : one upstream job {id, a, b, c}
//   ZERO_DOT_THREE : the constant 0.3 as a double, used by reference models
package fpu_job_pkg;

  localparam int FLEN = 64;
  localparam int ID_W = 8;

  localparam logic [63:0] ZERO_DOT_THREE = 64'h3FD3333333333333;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [FLEN-1:0] a;
    logic [FLEN-1:0] b;
    logic [FLEN-1:0] c;
  } job_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push, din     : write din when push && !full
//   pop, dout     : dout shows the head whenever !empty; pop advances it
//   full, empty   : status flags
//   count         : number of stored words (0..DEPTH)
// Pointers carry one extra MSB so full and empty are told apart when the
// low bits match. The head is read straight from the storage array, so no
// input reaches dout in the same cycle it is written.
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: it is only observed through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == DEPTH_W);

endmodule

// File: rtl/fpu_job_initiator.sv
// fpu_job_initiator: feeds jobs to the a**5 + 0.3*b - c compute block and
// pairs its in-order results with the job tags.
//   clk, rst                      : clock, asynchronous active-high reset
//   job_vld/job_rdy/job_id/job_*  : upstream job channel
//   arg_vld/arg_rdy/arg_*         : operands to the compute block
//   res_vld/res_rdy/res           : results from the compute block
//   out_vld/out_rdy/out_id/out_res: paired results downstream
//   outstanding                   : jobs accepted but not yet delivered
//   err_unexpected                : sticky, a result came with no pending tag
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and its payload stable until that transfer; ready
// never depends combinationally on the valid of the same channel.
module fpu_job_initiator #(
  parameter int FLEN    = 64,
  parameter int ID_W    = 8,
  parameter int MAX_OUT = 16,
  localparam int CW = $clog2(MAX_OUT) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            job_vld,
  output logic            job_rdy,
  input  logic [ID_W-1:0] job_id,
  input  logic [FLEN-1:0] job_a,
  input  logic [FLEN-1:0] job_b,
  input  logic [FLEN-1:0] job_c,
  output logic            arg_vld,
  input  logic            arg_rdy,
  output logic [FLEN-1:0] arg_a,
  output logic [FLEN-1:0] arg_b,
  output logic [FLEN-1:0] arg_c,
  input  logic            res_vld,
  output logic            res_rdy,
  input  logic [FLEN-1:0] res,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [ID_W-1:0] out_id,
  output logic [FLEN-1:0] out_res,
  output logic [CW-1:0]   outstanding,
  output logic            err_unexpected
);

  import fpu_job_pkg::*;

  localparam logic [CW-1:0] CREDITS = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [ID_W-1:0] arg_id;
  logic            job_fire;
  logic            arg_fire;
  logic            out_fire;
  logic            res_unexp;
  logic            res_push;

  logic [CW-1:0]   tag_count;
  logic [CW-1:0]   res_count;
  logic            tag_full;
  logic            tag_empty;
  logic            res_full;
  logic            res_empty;
  logic            unused_flags;

  // Credits come from the registered count only, so a same-cycle out fire
  // never reaches job_rdy combinationally.
  assign job_rdy  = (outstanding < CREDITS) && (!arg_vld || arg_rdy);
  assign job_fire = job_vld && job_rdy;
  assign arg_fire = arg_vld && arg_rdy;
  assign out_fire = out_vld && out_rdy;

  // Holding register: loads on job fire, clears valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arg_vld <= 1'b0;
      arg_id  <= '0;
      arg_a   <= '0;
      arg_b   <= '0;
      arg_c   <= '0;
    end else if (job_fire) begin
      arg_vld <= 1'b1;
      arg_id  <= job_id;
      arg_a   <= job_a;
      arg_b   <= job_b;
      arg_c   <= job_c;
    end else if (arg_fire) begin
      arg_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({job_fire, out_fire})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // tag_count - res_count equals (tags pushed - results pushed), because both
  // FIFOs pop together. Equal counts mean no tag is waiting for a result.
  assign res_rdy   = 1'b1;
  assign res_unexp = res_vld && (tag_count == res_count);
  assign res_push  = res_vld && res_rdy && !res_unexp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_unexpected <= 1'b0;
    else if (res_unexp) err_unexpected <= 1'b1;
  end

  fpu_sync_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (arg_fire),
    .din   (arg_id),
    .pop   (out_fire),
    .dout  (out_id),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fpu_sync_fifo #(.WIDTH(FLEN), .DEPTH(MAX_OUT)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .din   (res),
    .pop   (out_fire),
    .dout  (out_res),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  // A result is only stored once its tag is already queued, so a non-empty
  // result FIFO always has a matching tag head.
  assign out_vld = !res_empty && !tag_empty;

  // Credits bound both FIFOs to MAX_OUT entries, so the full flags never
  // gate anything; they are kept for visibility.
  assign unused_flags = tag_full ^ res_full;

endmodule

// File: tb/tb_fpu_job_initiator.sv
// tb_fpu_job_initiator: randomized bench with a transaction-level model of
// the initiator and a stub compute block with configurable latency.
module tb_fpu_job_initiator;
  import fpu_job_pkg::*;

  localparam int MAX_OUT = 16;
  localparam int CW      = $clog2(MAX_OUT) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            job_vld = 1'b0;
  logic            job_rdy;
  logic [ID_W-1:0] job_id = '0;
  logic [FLEN-1:0] job_a = '0, job_b = '0, job_c = '0;
  logic            arg_vld;
  logic            arg_rdy = 1'b0;
  logic [FLEN-1:0] arg_a, arg_b, arg_c;
  logic            res_vld = 1'b0;
  logic            res_rdy;
  logic [FLEN-1:0] res = '0;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [ID_W-1:0] out_id;
  logic [FLEN-1:0] out_res;
  logic [CW-1:0]   outstanding;
  logic            err_unexpected;

  fpu_job_initiator #(.FLEN(FLEN), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .job_vld(job_vld), .job_rdy(job_rdy), .job_id(job_id),
    .job_a(job_a), .job_b(job_b), .job_c(job_c),
    .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .arg_a(arg_a), .arg_b(arg_b), .arg_c(arg_c),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_res(out_res),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] formula(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
    real ra, rb, rc;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    rc = $bitstoreal(c);
    return $realtobits(ra * ra * ra * ra * ra + $bitstoreal(ZERO_DOT_THREE) * rb - rc);
  endfunction

  function automatic logic [63:0] rand_operand();
    return $realtobits($itor($urandom_range(0, 16)) / 4.0 - 2.0);
  endfunction

  // Scoreboard: {id, expected result} per accepted job, in acceptance order.
  logic [ID_W+FLEN-1:0] exp_q[$];
  int      credits_m;     // accepted, not yet delivered
  int      arrived_m;     // results received, not yet delivered
  int      pending_m;     // issued to the compute block, result not yet back
  bit      held_m;        // a job sits in the issue register
  job_t    held_job;
  bit      err_m;

  // Stub compute block: results due at given cycle, in order.
  int          stub_due[$];
  logic [63:0] stub_res[$];
  int          stub_lat = 16;

  job_t  cur_job;
  int    next_id = 0;
  int    jobs_left = 0;
  int    accepted = 0;
  int    cyc = 0;
  bit    inject_res = 1'b0;
  int    simul_seen = 0;
  logic [ID_W-1:0] last_out_id = '0;

  function automatic job_t new_job();
    job_t j;
    j.id = ID_W'(next_id);
    j.a  = rand_operand();
    j.b  = rand_operand();
    j.c  = rand_operand();
    next_id++;
    return j;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    stub_due.delete();
    stub_res.delete();
    credits_m = 0;
    arrived_m = 0;
    pending_m = 0;
    held_m    = 1'b0;
    err_m     = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered 1 time unit after a rising edge; leaves at the same point.
  task automatic step(input bit jv, input bit ar, input bit ordy);
    bit exp_jrdy, jf, af, of, rf, ru;
    job_vld = jv && (jobs_left > 0);
    job_id  = cur_job.id;
    job_a   = cur_job.a;
    job_b   = cur_job.b;
    job_c   = cur_job.c;
    arg_rdy = ar;
    out_rdy = ordy;
    if (inject_res) begin
      res_vld = 1'b1;
      res     = 64'h3FF0000000000000;
    end else if (stub_due.size() > 0 && stub_due[0] <= cyc) begin
      res_vld = 1'b1;
      res     = stub_res.pop_front();
      void'(stub_due.pop_front());
    end else begin
      res_vld = 1'b0;
      res     = {$urandom, $urandom};
    end

    @(negedge clk);
    exp_jrdy = (credits_m < MAX_OUT) && (!held_m || ar);
    check("job_rdy", job_rdy, exp_jrdy);
    check("arg_vld", arg_vld, held_m);
    if (held_m) begin
      check("arg_a", arg_a, held_job.a);
      check("arg_b", arg_b, held_job.b);
      check("arg_c", arg_c, held_job.c);
    end
    check("out_vld", out_vld, arrived_m > 0);
    if (arrived_m > 0) begin
      check("out_id", out_id, exp_q[0][ID_W+FLEN-1:FLEN]);
      check("out_res", out_res, exp_q[0][FLEN-1:0]);
    end
    check("outstanding", outstanding, credits_m);
    check("err_unexpected", err_unexpected, err_m);
    check("res_rdy", res_rdy, 1'b1);

    jf = job_vld && exp_jrdy;
    af = held_m && ar;
    of = (arrived_m > 0) && ordy;
    rf = res_vld;
    ru = rf && (pending_m == 0);
    if (jf && af && rf && of && credits_m == MAX_OUT - 1) simul_seen++;

    if (ru) err_m = 1'b1;
    if (af) begin
      stub_due.push_back(cyc + stub_lat);
      stub_res.push_back(formula(arg_a, arg_b, arg_c));
      pending_m++;
    end
    if (rf && !ru) begin
      pending_m--;
      arrived_m++;
    end
    if (of) begin
      last_out_id = exp_q[0][ID_W+FLEN-1:FLEN];
      void'(exp_q.pop_front());
      arrived_m--;
      credits_m--;
    end
    if (jf) begin
      exp_q.push_back({cur_job.id, formula(cur_job.a, cur_job.b, cur_job.c)});
      held_job = cur_job;
      held_m   = 1'b1;
      credits_m++;
      accepted++;
      jobs_left--;
      cur_job = new_job();
    end else if (af) begin
      held_m = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    job_vld = 1'b0;
    res_vld = 1'b0;
    inject_res = 1'b0;
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    jobs_left = 0;
    while ((credits_m > 0 || held_m) && budget < 300) begin
      step(1'b0, 1'b1, 1'b1);
      budget++;
    end
    check(tag, credits_m, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc0;
    clear_model();
    cur_job = new_job();

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    check("rst_arg_vld", arg_vld, 1'b0);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_unexpected, 1'b0);
    check("rst_res_rdy", res_rdy, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unexpected result with nothing issued.
    inject_res = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    inject_res = 1'b0;
    repeat (4) step(1'b0, 1'b1, 1'b1);
    check("unexp_sticky", err_unexpected, 1'b1);
    apply_reset();
    check("unexp_cleared", err_unexpected, 1'b0);

    // Back-to-back: 32 jobs at full rate; stub short enough that credits
    // never run out, so every cycle reaches job+arg+res+out fire at once.
    stub_lat  = 13;
    next_id   = 0;
    cur_job   = '{id: '0, a: 64'h4000000000000000, b: '0, c: '0};
    next_id   = 1;
    jobs_left = 32;
    acc0      = accepted;
    repeat (32) step(1'b1, 1'b1, 1'b1);
    check("b2b_accepted", accepted - acc0, 32);
    drain("b2b_drain");
    check("b2b_last_id", last_out_id, 8'd31);
    check("b2b_simul_seen", simul_seen > 0, 1'b1);

    // Credit limit: downstream stalled, 20 jobs offered.
    stub_lat  = 16;
    jobs_left = 20;
    acc0      = accepted;
    repeat (40) step(1'b1, 1'b1, 1'b0);
    check("credit_accepted", accepted - acc0, 16);
    check("credit_outstanding", outstanding, 16);
    check("credit_job_rdy", job_rdy, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("credit_freed", job_rdy, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    drain("credit_drain");

    // arg backpressure: arg_rdy alternates, job_vld constant.
    jobs_left = 12;
    acc0      = accepted;
    for (int i = 0; i < 40; i++) step(1'b1, (i % 2) == 0, 1'b1);
    check("bp_accepted", accepted - acc0, 12);
    drain("bp_drain");

    // Random traffic.
    jobs_left = 100000;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 50);
    drain("rand_drain");

    // Reset with 5 jobs in flight.
    jobs_left = 5;
    repeat (7) step(1'b1, 1'b1, 1'b0);
    check("mid_inflight", outstanding, 5);
    #2;
    rst = 1'b1;
    #1;
    check("mid_arg_vld", arg_vld, 1'b0);
    check("mid_out_vld", out_vld, 1'b0);
    check("mid_outstanding", outstanding, 0);
    job_vld = 1'b0;
    res_vld = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    next_id   = 8'h55;
    cur_job   = new_job();
    jobs_left = 1;
    acc0      = accepted;
    repeat (25) step(1'b1, 1'b1, 1'b1);
    check("mid_new_accepted", accepted - acc0, 1);
    check("mid_new_id", last_out_id, 8'h55);
    check("mid_no_err", err_unexpected, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
